// File: rtl/rs_pkg.sv
// Shared defines for the reservation station: widths, opcode codes and entry/issue records.
package rs_pkg;

    localparam int unsigned DATA_LEN   = 32;
    localparam int unsigned ADDR_LEN   = 32;
    localparam int unsigned OPENUM_LEN = 6;
    localparam int unsigned ROB_ID_LEN = 5;
    localparam int unsigned RS_SIZE    = 16;
    localparam int unsigned RS_IDX_LEN = $clog2(RS_SIZE);

    localparam logic [DATA_LEN-1:0] ZERO_WORD = '0;

    localparam logic [OPENUM_LEN-1:0] OPENUM_NOP  = 6'd0;
    localparam logic [OPENUM_LEN-1:0] OPENUM_ADD  = 6'd1;
    localparam logic [OPENUM_LEN-1:0] OPENUM_ADDI = 6'd2;
    localparam logic [OPENUM_LEN-1:0] OPENUM_SUB  = 6'd3;
    localparam logic [OPENUM_LEN-1:0] OPENUM_AND  = 6'd4;
    localparam logic [OPENUM_LEN-1:0] OPENUM_OR   = 6'd5;
    localparam logic [OPENUM_LEN-1:0] OPENUM_XOR  = 6'd6;
    localparam logic [OPENUM_LEN-1:0] OPENUM_SLT  = 6'd7;

    typedef struct packed {
        logic                  busy;
        logic [OPENUM_LEN-1:0] openum;
        logic [DATA_LEN-1:0]   v1;
        logic [ROB_ID_LEN-1:0] q1;
        logic [DATA_LEN-1:0]   v2;
        logic [ROB_ID_LEN-1:0] q2;
        logic [DATA_LEN-1:0]   imm;
        logic [ADDR_LEN-1:0]   pc;
        logic [ROB_ID_LEN-1:0] rob_id;
    } rs_entry_t;

    typedef struct packed {
        logic [OPENUM_LEN-1:0] openum;
        logic [DATA_LEN-1:0]   v1;
        logic [DATA_LEN-1:0]   v2;
        logic [DATA_LEN-1:0]   imm;
        logic [ADDR_LEN-1:0]   pc;
        logic [ROB_ID_LEN-1:0] rob_id;
    } rs_issue_t;

    localparam rs_issue_t ISSUE_NOP = '{
        openum: OPENUM_NOP,
        v1:     ZERO_WORD,
        v2:     ZERO_WORD,
        imm:    ZERO_WORD,
        pc:     ZERO_WORD,
        rob_id: '0
    };

    // Tag 0 means "value already valid", so it can never be woken by a broadcast.
    function automatic logic tag_hit(input logic [ROB_ID_LEN-1:0] q,
                                     input logic                  cdb_valid,
                                     input logic [ROB_ID_LEN-1:0] cdb_rob_id);
        return cdb_valid && (q != '0) && (q == cdb_rob_id);
    endfunction

endpackage

// File: rtl/rs_priority_enc.sv
// Lowest-index set-bit finder used for both free-slot and ready-entry selection.
module rs_priority_enc #(
    parameter int unsigned Width = 16,
    parameter int unsigned IdxW  = 4
) (
    input  logic [Width-1:0] vec_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = Width - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = i[IdxW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs.sv
// 16-entry reservation station: dispatch, dual-CDB wakeup, in-order-by-index issue.
// Define RS_DISPATCH_FWD_EN to forward same-cycle CDB results into the dispatched entry.
module rs
    import rs_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  disp_valid,
    input  logic [OPENUM_LEN-1:0] disp_openum,
    input  logic [DATA_LEN-1:0]   disp_imm,
    input  logic [ADDR_LEN-1:0]   disp_pc,
    input  logic [DATA_LEN-1:0]   disp_V1,
    input  logic [DATA_LEN-1:0]   disp_V2,
    input  logic [ROB_ID_LEN-1:0] disp_Q1,
    input  logic [ROB_ID_LEN-1:0] disp_Q2,
    input  logic [ROB_ID_LEN-1:0] disp_rob_id,
    input  logic                  alu_cdb_valid,
    input  logic [ROB_ID_LEN-1:0] alu_cdb_rob_id,
    input  logic [DATA_LEN-1:0]   alu_cdb_result,
    input  logic                  lsb_cdb_valid,
    input  logic [ROB_ID_LEN-1:0] lsb_cdb_rob_id,
    input  logic [DATA_LEN-1:0]   lsb_cdb_result,
    output logic                  full,
    output logic [OPENUM_LEN-1:0] ex_openum,
    output logic [DATA_LEN-1:0]   ex_V1,
    output logic [DATA_LEN-1:0]   ex_V2,
    output logic [DATA_LEN-1:0]   ex_imm,
    output logic [ADDR_LEN-1:0]   ex_pc,
    output logic [ROB_ID_LEN-1:0] ex_rob_id
);

    rs_entry_t ent_q [RS_SIZE];
    rs_entry_t ent_d [RS_SIZE];
    rs_issue_t ex_q;
    rs_issue_t ex_d;
    rs_entry_t disp_ent;

    logic [RS_SIZE-1:0]    busy_vec;
    logic [RS_SIZE-1:0]    ready_vec;
    logic [RS_SIZE-1:0]    free_vec;
    logic [RS_IDX_LEN-1:0] free_idx;
    logic [RS_IDX_LEN-1:0] ready_idx;
    logic                  free_found;
    logic                  ready_found;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && (ent_q[i].q1 == '0) && (ent_q[i].q2 == '0);
        end
    end

    assign free_vec = ~busy_vec;
    assign full     = &busy_vec;

    rs_priority_enc #(
        .Width (RS_SIZE),
        .IdxW  (RS_IDX_LEN)
    ) u_free_enc (
        .vec_i   (free_vec),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    rs_priority_enc #(
        .Width (RS_SIZE),
        .IdxW  (RS_IDX_LEN)
    ) u_ready_enc (
        .vec_i   (ready_vec),
        .idx_o   (ready_idx),
        .found_o (ready_found)
    );

    always_comb begin
        disp_ent = '{
            busy:   1'b1,
            openum: disp_openum,
            v1:     disp_V1,
            q1:     disp_Q1,
            v2:     disp_V2,
            q2:     disp_Q2,
            imm:    disp_imm,
            pc:     disp_pc,
            rob_id: disp_rob_id
        };
`ifdef RS_DISPATCH_FWD_EN
        if (tag_hit(disp_Q1, alu_cdb_valid, alu_cdb_rob_id)) begin
            disp_ent.v1 = alu_cdb_result;
            disp_ent.q1 = '0;
        end else if (tag_hit(disp_Q1, lsb_cdb_valid, lsb_cdb_rob_id)) begin
            disp_ent.v1 = lsb_cdb_result;
            disp_ent.q1 = '0;
        end
        if (tag_hit(disp_Q2, alu_cdb_valid, alu_cdb_rob_id)) begin
            disp_ent.v2 = alu_cdb_result;
            disp_ent.q2 = '0;
        end else if (tag_hit(disp_Q2, lsb_cdb_valid, lsb_cdb_rob_id)) begin
            disp_ent.v2 = lsb_cdb_result;
            disp_ent.q2 = '0;
        end
`endif
    end

    always_comb begin
        ent_d = ent_q;
        ex_d  = ex_q;
        if (rollback) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i].busy = 1'b0;
            end
            ex_d = ISSUE_NOP;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy) begin
                    if (tag_hit(ent_q[i].q1, alu_cdb_valid, alu_cdb_rob_id)) begin
                        ent_d[i].v1 = alu_cdb_result;
                        ent_d[i].q1 = '0;
                    end else if (tag_hit(ent_q[i].q1, lsb_cdb_valid, lsb_cdb_rob_id)) begin
                        ent_d[i].v1 = lsb_cdb_result;
                        ent_d[i].q1 = '0;
                    end
                    if (tag_hit(ent_q[i].q2, alu_cdb_valid, alu_cdb_rob_id)) begin
                        ent_d[i].v2 = alu_cdb_result;
                        ent_d[i].q2 = '0;
                    end else if (tag_hit(ent_q[i].q2, lsb_cdb_valid, lsb_cdb_rob_id)) begin
                        ent_d[i].v2 = lsb_cdb_result;
                        ent_d[i].q2 = '0;
                    end
                end
            end
            // Free slot comes from pre-edge busy bits, so it never collides with the issued slot.
            if (disp_valid && free_found) begin
                ent_d[free_idx] = disp_ent;
            end
            if (ready_found) begin
                ex_d.openum = ent_q[ready_idx].openum;
                ex_d.v1     = ent_q[ready_idx].v1;
                ex_d.v2     = ent_q[ready_idx].v2;
                ex_d.imm    = ent_q[ready_idx].imm;
                ex_d.pc     = ent_q[ready_idx].pc;
                ex_d.rob_id = ent_q[ready_idx].rob_id;
                ent_d[ready_idx].busy = 1'b0;
            end else begin
                ex_d = ISSUE_NOP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            ex_q <= ISSUE_NOP;
        end else begin
            ent_q <= ent_d;
            ex_q  <= ex_d;
        end
    end

    assign ex_openum = ex_q.openum;
    assign ex_V1     = ex_q.v1;
    assign ex_V2     = ex_q.v2;
    assign ex_imm    = ex_q.imm;
    assign ex_pc     = ex_q.pc;
    assign ex_rob_id = ex_q.rob_id;

endmodule

// File: tb/tb_rs.sv
// Self-checking bench for rs: directed scenarios plus randomized traffic against a reference model.
module tb_rs;
    import rs_pkg::*;

    localparam int EX_W = OPENUM_LEN + 4 * 32 + ROB_ID_LEN;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rdy;
    logic                  rollback;
    logic                  disp_valid;
    logic [OPENUM_LEN-1:0] disp_openum;
    logic [31:0]           disp_imm, disp_pc, disp_V1, disp_V2;
    logic [ROB_ID_LEN-1:0] disp_Q1, disp_Q2, disp_rob_id;
    logic                  alu_cdb_valid, lsb_cdb_valid;
    logic [ROB_ID_LEN-1:0] alu_cdb_rob_id, lsb_cdb_rob_id;
    logic [31:0]           alu_cdb_result, lsb_cdb_result;
    logic                  full;
    logic [OPENUM_LEN-1:0] ex_openum;
    logic [31:0]           ex_V1, ex_V2, ex_imm, ex_pc;
    logic [ROB_ID_LEN-1:0] ex_rob_id;
    logic [EX_W-1:0]       ex_bus;
    logic [EX_W-1:0]       exp_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ex_bus = {ex_openum, ex_V1, ex_V2, ex_imm, ex_pc, ex_rob_id};

    rs dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .disp_valid     (disp_valid),
        .disp_openum    (disp_openum),
        .disp_imm       (disp_imm),
        .disp_pc        (disp_pc),
        .disp_V1        (disp_V1),
        .disp_V2        (disp_V2),
        .disp_Q1        (disp_Q1),
        .disp_Q2        (disp_Q2),
        .disp_rob_id    (disp_rob_id),
        .alu_cdb_valid  (alu_cdb_valid),
        .alu_cdb_rob_id (alu_cdb_rob_id),
        .alu_cdb_result (alu_cdb_result),
        .lsb_cdb_valid  (lsb_cdb_valid),
        .lsb_cdb_rob_id (lsb_cdb_rob_id),
        .lsb_cdb_result (lsb_cdb_result),
        .full           (full),
        .ex_openum      (ex_openum),
        .ex_V1          (ex_V1),
        .ex_V2          (ex_V2),
        .ex_imm         (ex_imm),
        .ex_pc          (ex_pc),
        .ex_rob_id      (ex_rob_id)
    );

    // Reference model: a table of waiting instructions plus the last issued record.
    logic                  m_busy [RS_SIZE];
    logic [OPENUM_LEN-1:0] m_op   [RS_SIZE];
    logic [31:0]           m_v1   [RS_SIZE];
    logic [31:0]           m_v2   [RS_SIZE];
    logic [31:0]           m_imm  [RS_SIZE];
    logic [31:0]           m_pc   [RS_SIZE];
    logic [ROB_ID_LEN-1:0] m_q1   [RS_SIZE];
    logic [ROB_ID_LEN-1:0] m_q2   [RS_SIZE];
    logic [ROB_ID_LEN-1:0] m_rob  [RS_SIZE];
    logic [EX_W-1:0]       m_ex;

    function automatic logic [EX_W-1:0] mk_ex(input logic [OPENUM_LEN-1:0] op,
                                             input logic [31:0] v1, input logic [31:0] v2,
                                             input logic [31:0] imm, input logic [31:0] pc,
                                             input logic [ROB_ID_LEN-1:0] rob);
        return {op, v1, v2, imm, pc, rob};
    endfunction

    function automatic logic m_full();
        logic f;
        f = 1'b1;
        for (int i = 0; i < RS_SIZE; i++) if (!m_busy[i]) f = 1'b0;
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 1'b0;
        m_ex = mk_ex(OPENUM_NOP, 32'h0, 32'h0, 32'h0, 32'h0, '0);
    endtask

    task automatic model_step();
        int sel;
        int slot;
        logic [31:0] v1, v2;
        logic [ROB_ID_LEN-1:0] q1, q2;
        if (rst || rollback) begin
            model_reset();
        end else if (rdy) begin
            sel  = -1;
            slot = -1;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (sel < 0 && m_busy[i] && m_q1[i] == 0 && m_q2[i] == 0) sel = i;
                if (slot < 0 && !m_busy[i]) slot = i;
            end
            if (sel >= 0) m_ex = mk_ex(m_op[sel], m_v1[sel], m_v2[sel], m_imm[sel], m_pc[sel],
                                       m_rob[sel]);
            else m_ex = mk_ex(OPENUM_NOP, 32'h0, 32'h0, 32'h0, 32'h0, '0);
            for (int i = 0; i < RS_SIZE; i++) begin
                if (!m_busy[i]) continue;
                if (alu_cdb_valid && m_q1[i] != 0 && m_q1[i] == alu_cdb_rob_id) begin
                    m_v1[i] = alu_cdb_result; m_q1[i] = 0;
                end
                if (lsb_cdb_valid && m_q1[i] != 0 && m_q1[i] == lsb_cdb_rob_id) begin
                    m_v1[i] = lsb_cdb_result; m_q1[i] = 0;
                end
                if (alu_cdb_valid && m_q2[i] != 0 && m_q2[i] == alu_cdb_rob_id) begin
                    m_v2[i] = alu_cdb_result; m_q2[i] = 0;
                end
                if (lsb_cdb_valid && m_q2[i] != 0 && m_q2[i] == lsb_cdb_rob_id) begin
                    m_v2[i] = lsb_cdb_result; m_q2[i] = 0;
                end
            end
            if (sel >= 0) m_busy[sel] = 1'b0;
            if (disp_valid && slot >= 0) begin
                v1 = disp_V1; q1 = disp_Q1; v2 = disp_V2; q2 = disp_Q2;
`ifdef RS_DISPATCH_FWD_EN
                if (alu_cdb_valid && q1 != 0 && q1 == alu_cdb_rob_id) begin
                    v1 = alu_cdb_result; q1 = 0;
                end else if (lsb_cdb_valid && q1 != 0 && q1 == lsb_cdb_rob_id) begin
                    v1 = lsb_cdb_result; q1 = 0;
                end
                if (alu_cdb_valid && q2 != 0 && q2 == alu_cdb_rob_id) begin
                    v2 = alu_cdb_result; q2 = 0;
                end else if (lsb_cdb_valid && q2 != 0 && q2 == lsb_cdb_rob_id) begin
                    v2 = lsb_cdb_result; q2 = 0;
                end
`endif
                m_busy[slot] = 1'b1; m_op[slot] = disp_openum;
                m_v1[slot] = v1; m_q1[slot] = q1; m_v2[slot] = v2; m_q2[slot] = q2;
                m_imm[slot] = disp_imm; m_pc[slot] = disp_pc; m_rob[slot] = disp_rob_id;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0; disp_openum = OPENUM_NOP; disp_imm = '0; disp_pc = '0;
        disp_V1 = '0; disp_V2 = '0; disp_Q1 = '0; disp_Q2 = '0; disp_rob_id = '0;
        alu_cdb_valid = 1'b0; alu_cdb_rob_id = '0; alu_cdb_result = '0;
        lsb_cdb_valid = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_result = '0;
    endtask

    task automatic drive(input logic [OPENUM_LEN-1:0] op, input logic [31:0] v1,
                         input logic [ROB_ID_LEN-1:0] q1, input logic [31:0] v2,
                         input logic [ROB_ID_LEN-1:0] q2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [ROB_ID_LEN-1:0] rob);
        disp_valid = 1'b1; disp_openum = op; disp_V1 = v1; disp_Q1 = q1;
        disp_V2 = v2; disp_Q2 = q2; disp_imm = imm; disp_pc = pc; disp_rob_id = rob;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; idle(); model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_bus = mk_ex(OPENUM_NOP, 32'h0, 32'h0, 32'h0, 32'h0, '0);
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL reset_ex: got %h want %h", ex_bus, exp_bus);
        end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        rst = 1'b0;
        drive(OPENUM_ADD, 32'd1, 5'd0, 32'd2, 5'd0, 32'd0, 32'h40, 5'd1);
        tick(); idle(); tick();
        checks++;
        if (ex_openum !== OPENUM_ADD) begin
            errors++; $display("FAIL pre_async_issue: got %h want %h", ex_openum, OPENUM_ADD);
        end
        #2 rst = 1'b1; model_reset();
        #1;
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL async_reset_ex: got %h want %h", ex_bus, exp_bus);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        drive(OPENUM_ADD, 32'd5, 5'd0, 32'd7, 5'd0, 32'd0, 32'h100, 5'd2);
        tick(); idle();
        checks++;
        if (ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL basic_latency: got %h want %h", ex_openum, OPENUM_NOP);
        end
        tick();
        exp_bus = mk_ex(OPENUM_ADD, 32'd5, 32'd7, 32'd0, 32'h100, 5'd2);
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL basic_issue: got %h want %h", ex_bus, exp_bus);
        end
        tick();
        checks++;
        if (ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL basic_one_cycle: got %h want %h", ex_openum, OPENUM_NOP);
        end
    endtask

    task automatic test_wakeup();
        drive(OPENUM_ADDI, 32'd0, 5'd3, 32'd0, 5'd0, 32'd4, 32'h200, 5'd5);
        tick(); idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (ex_openum !== OPENUM_NOP) begin
                errors++; $display("FAIL wake_wait%0d: got %h want %h", c, ex_openum, OPENUM_NOP);
            end
        end
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 5'd3; alu_cdb_result = 32'h10;
        tick(); idle();
        checks++;
        if (ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL wake_same_edge: got %h want %h", ex_openum, OPENUM_NOP);
        end
        tick();
        exp_bus = mk_ex(OPENUM_ADDI, 32'h10, 32'd0, 32'd4, 32'h200, 5'd5);
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL wake_issue: got %h want %h", ex_bus, exp_bus);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < RS_SIZE; i++) begin
            drive(OPENUM_SUB, 32'(i), 5'd9, 32'(i * 3), 5'd0, 32'(i), 32'(32'h300 + 4 * i),
                  ROB_ID_LEN'(i + 1));
            tick();
        end
        idle();
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", full); end
        drive(OPENUM_ADD, 32'd1, 5'd0, 32'd1, 5'd0, 32'd99, 32'h3F0, 5'd20);
        tick(); idle();
        checks++;
        if (full !== 1'b1 || ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL full_drop: got full=%b op=%h want full=1 op=0", full, ex_openum);
        end
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 5'd9; lsb_cdb_result = 32'h55;
        tick(); idle();
        for (int i = 0; i < RS_SIZE; i++) begin
            tick();
            exp_bus = mk_ex(OPENUM_SUB, 32'h55, 32'(i * 3), 32'(i), 32'(32'h300 + 4 * i),
                            ROB_ID_LEN'(i + 1));
            checks++;
            if (ex_bus !== exp_bus) begin
                errors++; $display("FAIL full_order%0d: got %h want %h", i, ex_bus, exp_bus);
            end
        end
        tick();
        checks++;
        if (full !== 1'b0 || ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL full_drain: got full=%b op=%h want full=0 op=0", full, ex_openum);
        end
    endtask

    task automatic test_dual_cdb();
        drive(OPENUM_AND, 32'd0, 5'd2, 32'd0, 5'd4, 32'd0, 32'h400, 5'd6);
        tick(); idle();
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 5'd2; alu_cdb_result = 32'd1;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 5'd4; lsb_cdb_result = 32'd2;
        tick(); idle(); tick();
        exp_bus = mk_ex(OPENUM_AND, 32'd1, 32'd2, 32'd0, 32'h400, 5'd6);
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL dual_cdb: got %h want %h", ex_bus, exp_bus);
        end
        tick();
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 5; i++) begin
            drive(OPENUM_OR, 32'(i), 5'd9, 32'd0, 5'd0, 32'd0, 32'h500, ROB_ID_LEN'(i + 1));
            tick();
        end
        rollback = 1'b1;
        drive(OPENUM_ADD, 32'd1, 5'd0, 32'd1, 5'd0, 32'd0, 32'h520, 5'd7);
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 5'd9; alu_cdb_result = 32'd3;
        tick(); rollback = 1'b0; idle();
        checks++;
        if (full !== 1'b0 || ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL rollback_clear: got full=%b op=%h want 0 0", full, ex_openum);
        end
        tick();
        checks++;
        if (ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL rollback_disp_drop: got %h want %h", ex_openum, OPENUM_NOP);
        end
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 5'd9; lsb_cdb_result = 32'd4;
        tick(); idle(); tick();
        checks++;
        if (ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL rollback_flushed: got %h want %h", ex_openum, OPENUM_NOP);
        end
    endtask

    task automatic test_freeze();
        rdy = 1'b0;
        drive(OPENUM_XOR, 32'd1, 5'd0, 32'd2, 5'd0, 32'd3, 32'h600, 5'd8);
        tick(); idle(); tick(); rdy = 1'b1; tick();
        checks++;
        if (ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL freeze_disp_drop: got %h want %h", ex_openum, OPENUM_NOP);
        end
        drive(OPENUM_XOR, 32'd1, 5'd0, 32'd2, 5'd0, 32'd3, 32'h600, 5'd8);
        tick(); idle(); tick();
        exp_bus = mk_ex(OPENUM_XOR, 32'd1, 32'd2, 32'd3, 32'h600, 5'd8);
        rdy = 1'b0; tick();
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL freeze_hold: got %h want %h", ex_bus, exp_bus);
        end
        rdy = 1'b1; tick();
        checks++;
        if (ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL freeze_resume: got %h want %h", ex_openum, OPENUM_NOP);
        end
    endtask

    task automatic test_fwd();
        drive(OPENUM_SLT, 32'd1, 5'd0, 32'd0, 5'd6, 32'd0, 32'h700, 5'd9);
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 5'd6; alu_cdb_result = 32'hAB;
        tick(); idle(); tick();
`ifdef RS_DISPATCH_FWD_EN
        exp_bus = mk_ex(OPENUM_SLT, 32'd1, 32'hAB, 32'd0, 32'h700, 5'd9);
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL fwd_issue: got %h want %h", ex_bus, exp_bus);
        end
`else
        checks++;
        if (ex_openum !== OPENUM_NOP) begin
            errors++; $display("FAIL nofwd_wait: got %h want %h", ex_openum, OPENUM_NOP);
        end
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 5'd6; alu_cdb_result = 32'hCD;
        tick(); idle(); tick();
        exp_bus = mk_ex(OPENUM_SLT, 32'd1, 32'hCD, 32'd0, 32'h700, 5'd9);
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL nofwd_issue: got %h want %h", ex_bus, exp_bus);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        rollback = 1'b1; tick(); rollback = 1'b0;
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy      = ($urandom_range(0, 7) != 0);
            rollback = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) != 0) begin
                drive(OPENUM_LEN'($urandom_range(1, 7)), $urandom(),
                      ($urandom_range(0, 1) != 0) ? 5'd0 : ROB_ID_LEN'($urandom_range(1, 7)),
                      $urandom(),
                      ($urandom_range(0, 1) != 0) ? 5'd0 : ROB_ID_LEN'($urandom_range(1, 7)),
                      $urandom(), $urandom(), ROB_ID_LEN'($urandom_range(1, 31)));
            end
            if ($urandom_range(0, 2) == 0) begin
                alu_cdb_valid = 1'b1; alu_cdb_rob_id = ROB_ID_LEN'($urandom_range(1, 7));
                alu_cdb_result = $urandom();
            end
            if ($urandom_range(0, 2) == 0) begin
                lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = ROB_ID_LEN'($urandom_range(1, 7));
                lsb_cdb_result = $urandom();
                // Producer tags are unique, so both ports never broadcast the same one.
                if (alu_cdb_valid && lsb_cdb_rob_id == alu_cdb_rob_id) lsb_cdb_valid = 1'b0;
            end
            tick();
            checks++;
            if (ex_bus !== m_ex) begin
                errors++; $display("FAIL rand_ex%0d: got %h want %h", c, ex_bus, m_ex);
            end
            checks++;
            if (full !== m_full()) begin
                errors++; $display("FAIL rand_full%0d: got %b want %b", c, full, m_full());
            end
        end
        idle(); rdy = 1'b1; rollback = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_dual_cdb();
        test_rollback();
        test_freeze();
        test_fwd();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs.md
RS -- requirements
Module: RS

Interface
REQ-001 SHALL provide: clk  in  1  single clock, rising-edge.
REQ-002 SHALL provide: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: rdy  in  1  global enable; low freezes all state.
REQ-004 SHALL provide: rollback  in  1  misprediction flush.
REQ-005 SHALL provide: disp_valid  in  1  dispatch request.
REQ-006 SHALL provide: disp_openum  in  OPENUM_LEN  operation; disp_imm, disp_pc  in  32  immediate, instruction address.
REQ-007 SHALL provide: disp_V1, disp_V2  in  32  operand values; disp_Q1, disp_Q2  in  ROB_ID_LEN  producer tags; 0 = value valid.
REQ-008 SHALL provide: disp_rob_id  in  ROB_ID_LEN  destination tag.
REQ-009 SHALL provide: alu_cdb_valid, lsb_cdb_valid  in  1; alu_cdb_rob_id, lsb_cdb_rob_id  in  ROB_ID_LEN; alu_cdb_result, lsb_cdb_result  in  32.
REQ-010 SHALL provide: full  out  1  no free entry.
REQ-011 SHALL provide: ex_openum  out  OPENUM_LEN; ex_V1, ex_V2, ex_imm, ex_pc  out  32; ex_rob_id  out  ROB_ID_LEN; all go to the execute unit.

Function
REQ-012 SHALL hold RS_SIZE = 16 entries, each: busy, openum, V1, Q1, V2, Q2, imm, pc, rob_id.
REQ-013 SHALL drive full combinationally = all 16 busy bits set; disp_valid while full is ignored.
REQ-014 SHALL write a dispatch into the lowest-index non-busy entry at the edge; the entry becomes visible to selection from the next cycle.
REQ-015 SHALL, for every busy entry with Qn equal to a valid CDB rob_id, load Vn from that port's result and clear Qn to 0 at the edge; both ports are checked independently and in the same cycle.
REQ-016 SHALL treat an entry as ready when busy, Q1 == 0 and Q2 == 0; a wakeup at edge E allows issue no earlier than edge E+1.
REQ-017 SHALL at each edge select the lowest-index ready entry, register its fields onto ex_* and clear its busy bit; with no ready entry, ex_openum = OPENUM_NOP and the other ex_* outputs = 0.
REQ-018 SHALL issue at most one entry per cycle; ex_* is valid for exactly one cycle per issue.
REQ-019 SHALL give a minimum dispatch-to-ex_openum latency of 2 edges (dispatch edge, issue edge).
REQ-020 SHALL, when an entry is issued and a new dispatch occurs in the same cycle, compute the free slot from pre-edge busy bits; the issued slot is reusable from the next cycle.
REQ-021 SHALL, on rollback high at an edge, clear all busy bits, drive ex_openum = OPENUM_NOP, and ignore any same-cycle dispatch and CDB data.
REQ-022 SHALL, when rdy is low and rollback is low, hold every register unchanged.

Reset
REQ-023 SHALL, while rst is high, asynchronously clear all busy bits, drive ex_openum = OPENUM_NOP, and drive ex_V1/V2/imm/pc/rob_id = 0; full reads 0.
REQ-024 SHALL give rst priority over rollback and rdy.

Configuration
REQ-025 SHALL, with RS_DISPATCH_FWD_EN defined, compare disp_Q1/disp_Q2 against both valid CDB ports in the dispatch cycle; on a match, store the CDB result and Qn = 0.
REQ-026 SHALL, without RS_DISPATCH_FWD_EN, store disp_Qn unchanged; the ROB then guarantees that no tag in flight for dispatch matches the same-cycle CDB.

Structure
REQ-027 SHALL take OPENUM_* codes, OPENUM_LEN, DATA_LEN, ADDR_LEN, ROB_ID_LEN, RS_SIZE and ZERO_WORD from the shared defines file.
REQ-028 SHALL factor the lowest-index search into one sub-module, RS_PRIORITY_ENC (16-bit vector in, 4-bit index plus found flag out), instantiated twice: once for free slots, once for ready entries.

Verification
REQ-029 Dispatch ADD, Q1 = Q2 = 0, V1 = 5, V2 = 7 -> 2 edges later ex_openum = ADD, ex_V1 = 5, ex_V2 = 7 for one cycle, then NOP.
REQ-030 Dispatch ADDI, Q1 = 3; 4 cycles later alu_cdb rob_id = 3, result = 0x10 -> issued at the following edge with ex_V1 = 0x10.
REQ-031 Fill 16 entries, all with Q1 = 9 -> full = 1 and a 17th dispatch is dropped; one lsb_cdb rob_id = 9 wakeup -> entries issue in index order 0..15, one per cycle.
REQ-032 Simultaneous alu_cdb (tag 2, result 1) and lsb_cdb (tag 4, result 2) with an entry Q1 = 2, Q2 = 4 -> issues with V1 = 1, V2 = 2.
REQ-033 Rollback with 5 busy entries and a same-cycle dispatch -> next cycle full = 0, ex_openum = NOP, no issue occurs.
REQ-034 With RS_DISPATCH_FWD_EN, dispatch Q2 = 6 in the same cycle as alu_cdb tag 6, result 0xAB -> issues 2 edges later with ex_V2 = 0xAB.
